// File: rtl/grf_wb_arbiter_if.sv
// Bundle of the GRF write-port arbiter signals: WB port P, multi-cycle port M,
// decode read addresses, and the arbitrated GRF write port.
interface grf_wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             p_we;
    logic [4:0]       p_a3;
    logic [31:0]      p_wd;
    logic [31:0]      p_pc;
    logic             m_valid;
    logic             m_ready;
    logic [4:0]       m_a3;
    logic [31:0]      m_wd;
    logic [31:0]      m_pc;
    logic [4:0]       rd_a1;
    logic [4:0]       rd_a2;
    logic             pend1;
    logic             pend2;
    logic             hold_req;
    logic             grf_we;
    logic [4:0]       grf_a3;
    logic [31:0]      grf_wd;
    logic [31:0]      grf_pc;
    logic [CNT_W-1:0] fifo_count;

    // Arbiter side
    modport slave (
        input  p_we, p_a3, p_wd, p_pc,
        input  m_valid, m_a3, m_wd, m_pc,
        input  rd_a1, rd_a2,
        output m_ready, pend1, pend2, hold_req,
        output grf_we, grf_a3, grf_wd, grf_pc, fifo_count
    );

    // Pipeline / environment side
    modport master (
        output p_we, p_a3, p_wd, p_pc,
        output m_valid, m_a3, m_wd, m_pc,
        output rd_a1, rd_a2,
        input  m_ready, pend1, pend2, hold_req,
        input  grf_we, grf_a3, grf_wd, grf_pc, fifo_count
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Single GRF write port shared between WB (always wins) and a FIFO of late
// multi-cycle results that drain in idle WB cycles, with hazard and starvation flags.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    grf_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_MAX + 1);

    logic [4:0]        a3_q [DEPTH];
    logic [31:0]       wd_q [DEPTH];
    logic [31:0]       pc_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              hold_q, hold_d;

    logic              empty_c, p_grant_c, pop_c, push_c, ready_c;
    logic [DEPTH-1:0]  kill_c, match1_c, match2_c;

    // Grant, handshake and per-slot address matches
    always_comb begin
        empty_c   = (count_q == '0);
        ready_c   = !reset && (count_q < CNT_W'(DEPTH));
        p_grant_c = bus.p_we && (bus.p_a3 != 5'd0);
        pop_c     = !reset && !p_grant_c && !empty_c;
        push_c    = ready_c && bus.m_valid && (bus.m_a3 != 5'd0);
        kill_c    = '0;
        match1_c  = '0;
        match2_c  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_c[i]   = p_grant_c && live_q[i] && (a3_q[i] == bus.p_a3);
            match1_c[i] = live_q[i] && (a3_q[i] == bus.rd_a1);
            match2_c[i] = live_q[i] && (a3_q[i] == bus.rd_a2);
        end
    end

    // GRF write port; address/data are zeroed whenever no write happens
    always_comb begin
        bus.grf_we = 1'b0;
        bus.grf_a3 = 5'd0;
        bus.grf_wd = 32'd0;
        bus.grf_pc = 32'd0;
        if (!reset) begin
            if (p_grant_c) begin
                bus.grf_we = 1'b1;
                bus.grf_a3 = bus.p_a3;
                bus.grf_wd = bus.p_wd;
                bus.grf_pc = bus.p_pc;
            end else if (pop_c && live_q[head_q]) begin
                bus.grf_we = 1'b1;
                bus.grf_a3 = a3_q[head_q];
                bus.grf_wd = wd_q[head_q];
                bus.grf_pc = pc_q[head_q];
            end
        end
    end

    assign bus.m_ready    = ready_c;
    assign bus.pend1      = (bus.rd_a1 != 5'd0) && (|match1_c);
    assign bus.pend2      = (bus.rd_a2 != 5'd0) && (|match2_c);
    assign bus.hold_req   = hold_q;
    assign bus.fifo_count = count_q;

    // Next state: a same-cycle push is applied after the kill so it stays live
    always_comb begin
        live_d  = live_q & ~kill_c;
        head_d  = head_q;
        tail_d  = tail_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (pop_c) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end
        if (push_c) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PTR_W'(1);
        end
        if (empty_c || pop_c) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(STARVE_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        if (pop_c) begin
            hold_d = 1'b0;
        end else if (wait_q == WAIT_W'(STARVE_MAX)) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by live/count
    always_ff @(posedge clk) begin
        if (push_c) begin
            a3_q[tail_q] <= bus.m_a3;
            wd_q[tail_q] <= bus.m_wd;
            pc_q[tail_q] <= bus.m_pc;
        end
    end
endmodule
